// File: rtl/seq_ram_loader.sv
// seq_ram_loader: packs two 2-bit nucleotide streams into 8-bit words and shares one RAM write port
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               one-cycle pulse; latches len_a/len_b and starts a load (IDLE or DONE only)
//   len_a, len_b        sequence lengths in symbols
//   a_valid, a_sym      sequence A symbol stream, handshaken with a_ready
//   b_valid, b_sym      sequence B symbol stream, handshaken with b_ready
//   ram_we              registered one-cycle write strobe
//   ram_sel             target bank (0 = A, 1 = B)
//   ram_addr            word address within the selected bank
//   ram_wdata           packed word, slot 0 in the LSBs
//   busy                high while loading
//   done_a, done_b      stream fully written; held until the next start
//   done                both streams written
//
// Build option: define SEQ_LOADER_RR_EN for round-robin arbitration; otherwise A has fixed priority.
module seq_ram_loader #(
    parameter int SYM_W         = 2,
    parameter int SYMS_PER_WORD = 4,
    parameter int ADDR_W        = 6,
    parameter int LEN_W         = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_W-1:0]               len_a,
    input  logic [LEN_W-1:0]               len_b,
    input  logic                           a_valid,
    input  logic [SYM_W-1:0]               a_sym,
    input  logic                           b_valid,
    input  logic [SYM_W-1:0]               b_sym,
    output logic                           a_ready,
    output logic                           b_ready,
    output logic                           ram_we,
    output logic                           ram_sel,
    output logic [ADDR_W-1:0]              ram_addr,
    output logic [SYM_W*SYMS_PER_WORD-1:0] ram_wdata,
    output logic                           busy,
    output logic                           done_a,
    output logic                           done_b,
    output logic                           done
);
    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    localparam int SLOT_W = $clog2(SYMS_PER_WORD);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q  [2];
    logic [LEN_W-1:0]    len_d  [2];
    logic [LEN_W-1:0]    cnt_q  [2];
    logic [LEN_W-1:0]    cnt_d  [2];
    logic [WORD_W-1:0]   pack_q [2];
    logic [WORD_W-1:0]   pack_d [2];
    logic [SLOT_W-1:0]   slot_q [2];
    logic [SLOT_W-1:0]   slot_d [2];
    logic [ADDR_W-1:0]   addr_q [2];
    logic [ADDR_W-1:0]   addr_d [2];
    logic [SYM_W-1:0]    sym    [2];
    logic [1:0]          pend_q, pend_d, done_q, done_d;
    logic [1:0]          vld, rdy, fire, gnt;
    logic                restart;
    logic                ram_we_q, ram_we_d, ram_sel_q, ram_sel_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]   ram_wdata_q, ram_wdata_d;
`ifdef SEQ_LOADER_RR_EN
    logic                rr_q, rr_d;
`endif

    assign vld = {b_valid, a_valid};
    assign sym[0] = a_sym;
    assign sym[1] = b_sym;

    // Arbiter: one pending word per cycle. A channel cannot re-pend before its
    // ready reasserts, so fixed priority still guarantees service to B.
`ifdef SEQ_LOADER_RR_EN
    always_comb begin
        gnt  = (pend_q[0] && !(pend_q[1] && rr_q)) ? 2'b01 : pend_q[1] ? 2'b10 : 2'b00;
        rr_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : rr_q;
    end
`else
    always_comb gnt = pend_q[0] ? 2'b01 : pend_q[1] ? 2'b10 : 2'b00;
`endif

    always_comb begin
        restart = start && (state_q == IDLE || state_q == DONE);
        state_d = state_q;
        if (restart)
            state_d = LOAD;
        else if (state_q == LOAD && done_q == 2'b11)
            state_d = DONE;
        pend_d = pend_q;
        done_d = done_q;
        for (int i = 0; i < 2; i++) begin
            rdy[i]    = state_q == LOAD && !pend_q[i] && cnt_q[i] < len_q[i];
            fire[i]   = vld[i] && rdy[i];
            len_d[i]  = len_q[i];
            cnt_d[i]  = cnt_q[i];
            pack_d[i] = pack_q[i];
            slot_d[i] = slot_q[i];
            addr_d[i] = addr_q[i];
            if (restart) begin
                len_d[i]  = (i == 0) ? len_a : len_b;
                cnt_d[i]  = '0;
                pack_d[i] = '0;
                slot_d[i] = '0;
                addr_d[i] = '0;
                pend_d[i] = 1'b0;
                done_d[i] = 1'b0;
            end else begin
                if (fire[i]) begin
                    for (int s = 0; s < SYMS_PER_WORD; s++)
                        if (slot_q[i] == SLOT_W'(s))
                            pack_d[i][s*SYM_W +: SYM_W] = sym[i];
                    slot_d[i] = slot_q[i] + 1'b1;
                    cnt_d[i]  = cnt_q[i] + 1'b1;
                    // Full word, or the final symbol of a short tail; the
                    // cleared pack register leaves unfilled slots at zero.
                    pend_d[i] = slot_q[i] == SLOT_W'(SYMS_PER_WORD - 1) || cnt_q[i] + 1'b1 == len_q[i];
                end
                if (gnt[i]) begin
                    pend_d[i] = 1'b0;
                    addr_d[i] = addr_q[i] + 1'b1;
                    pack_d[i] = '0;
                    slot_d[i] = '0;
                end
                done_d[i] = done_q[i] || (state_q == LOAD && cnt_q[i] == len_q[i] && !pend_q[i]);
            end
        end
        ram_we_d    = |gnt;
        ram_sel_d   = |gnt ? gnt[1] : ram_sel_q;
        ram_addr_d  = gnt[1] ? addr_q[1] : gnt[0] ? addr_q[0] : ram_addr_q;
        ram_wdata_d = gnt[1] ? pack_q[1] : gnt[0] ? pack_q[0] : ram_wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            done_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            for (int i = 0; i < 2; i++) begin
                len_q[i]  <= '0;
                cnt_q[i]  <= '0;
                pack_q[i] <= '0;
                slot_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            ram_we_q    <= ram_we_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            for (int i = 0; i < 2; i++) begin
                len_q[i]  <= len_d[i];
                cnt_q[i]  <= cnt_d[i];
                pack_q[i] <= pack_d[i];
                slot_q[i] <= slot_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

`ifdef SEQ_LOADER_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_q <= 1'b0;
        else
            rr_q <= rr_d;
    end
`endif

    assign a_ready   = rdy[0];
    assign b_ready   = rdy[1];
    assign ram_we    = ram_we_q;
    assign ram_sel   = ram_sel_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = state_q == LOAD;
    assign done      = state_q == DONE;
    assign done_a    = done_q[0];
    assign done_b    = done_q[1];
endmodule

// File: tb/tb_seq_ram_loader.sv
// tb_seq_ram_loader: scoreboard bench for seq_ram_loader with directed symbol streams
module tb_seq_ram_loader;
    logic       clk = 0, rst = 1, start = 0;
    logic [7:0] len_a = 0, len_b = 0;
    logic       a_valid = 0, b_valid = 0;
    logic [1:0] a_sym = 0, b_sym = 0;
    logic       a_ready, b_ready, ram_we, ram_sel, busy, done_a, done_b, done;
    logic [5:0] ram_addr;
    logic [7:0] ram_wdata;

    int checks = 0, failures = 0;
    logic [14:0] exp_q[$];
    logic [14:0] mon_e;

    seq_ram_loader dut (
        .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
        .a_valid(a_valid), .a_sym(a_sym), .b_valid(b_valid), .b_sym(b_sym),
        .a_ready(a_ready), .b_ready(b_ready), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
        .done_a(done_a), .done_b(done_b), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic sel, input logic [5:0] addr, input logic [7:0] data);
        exp_q.push_back({sel, addr, data});
    endtask

    // Monitor: every write strobe pops one expected {sel, addr, data}
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%0h expected none", ram_sel, ram_addr, ram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ram_write", {17'd0, ram_sel, ram_addr, ram_wdata}, {17'd0, mon_e});
            end
        end
    end

    task automatic drive_a(input logic [31:0] v, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_valid = 1;
            a_sym = v[2*i +: 2];
            t = 0;
            while (!a_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                chk("a_ready_timeout", 32'd0, 32'd1);
                a_valid = 0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        a_valid = 0;
    endtask

    task automatic drive_b(input logic [31:0] v, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b_valid = 1;
            b_sym = v[2*i +: 2];
            t = 0;
            while (!b_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) begin
                chk("b_ready_timeout", 32'd0, 32'd1);
                b_valid = 0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        b_valid = 0;
    endtask

    task automatic do_start(input logic [7:0] la, input logic [7:0] lb);
        @(negedge clk);
        len_a = la;
        len_b = lb;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, {29'd0, done, done_a, done_b}, 32'd7);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {30'd0, a_ready, b_ready}, 0);
        chk("rst_we_sel", {30'd0, ram_we, ram_sel}, 0);
        chk("rst_addr", {26'd0, ram_addr}, 0);
        chk("rst_wdata", {24'd0, ram_wdata}, 0);
        chk("rst_status", {28'd0, busy, done_a, done_b, done}, 0);
        rst = 0;

        // ACGT GTCA into A, B empty
        push(0, 0, 8'b11_10_01_00);
        push(0, 1, 8'b00_01_11_10);
        do_start(8, 0);
        fork
            drive_a(32'h1EE4, 8);
            begin
                repeat (2) @(negedge clk);
                chk("t1_done_b_early", done_b, 1);
                chk("t1_done_a_low", done_a, 0);
                chk("t1_busy", busy, 1);
            end
        join
        wait_done("t1_done");

        // TTTTG: tail word zero-padded
        push(0, 0, 8'hFF);
        push(0, 1, 8'h02);
        do_start(5, 0);
        drive_a(32'h2FF, 5);
        wait_done("t2_done");

        // both streams pend on the same edge; A wins first
        push(0, 0, 8'hE4);
        push(1, 0, 8'h1B);
        do_start(4, 4);
        fork
            drive_a(32'hE4, 4);
            drive_b(32'h1B, 4);
        join
        wait_done("t3_done");

        // two words per stream, continuous: writes alternate A,B,A,B
        push(0, 0, 8'hE4);
        push(1, 0, 8'hAA);
        push(0, 1, 8'h1E);
        push(1, 1, 8'h55);
        do_start(8, 8);
        fork
            drive_a(32'h1EE4, 8);
            drive_b(32'h55AA, 8);
        join
        wait_done("t4_done");

        // reset after three symbols abandons the load
        do_start(8, 0);
        drive_a(32'h3F, 3);
        @(negedge clk);
        rst = 1;
        #1;
        chk("t5_rst_ready", {30'd0, a_ready, b_ready}, 0);
        chk("t5_rst_we_sel", {30'd0, ram_we, ram_sel}, 0);
        chk("t5_rst_addr", {26'd0, ram_addr}, 0);
        chk("t5_rst_wdata", {24'd0, ram_wdata}, 0);
        chk("t5_rst_status", {28'd0, busy, done_a, done_b, done}, 0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("t5_idle", {30'd0, busy, a_ready}, 0);
        push(0, 0, 8'h72);
        do_start(4, 0);
        drive_a(32'h72, 4);
        wait_done("t5_done");

        // start during LOAD is ignored
        push(0, 0, 8'hC6);
        push(0, 1, 8'hB4);
        do_start(8, 0);
        fork
            drive_a(32'hB4C6, 8);
            begin
                repeat (3) @(negedge clk);
                len_a = 4;
                start = 1;
                @(negedge clk);
                start = 0;
                chk("t6_busy_after_start", busy, 1);
            end
        join
        wait_done("t6_done");

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
